matmul_sum_engine: RTL

- Parametrised successor to the fixed-size matrix-multiply summing lab block.
- Holds two N×N unsigned operand matrices A and B in internal banked register memory, loaded through a write port.
- On start, computes C = A×B, accumulating either the sum of all C elements (MODE 0) or the trace of C (MODE 1) using LANES parallel multipliers.
- Reports the result, a cycle count and an active-low completion flag.
- Sits as a top-level compute tile under the lab top, driven by a loader/controller or testbench.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/mac_lane_tree.sv | 37 +++
 rtl/matmul_sum_engine.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply summing engine.
// Holds the controller state encoding, result-mode encoding and run-length helper.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_SUM   = 1'b0;
  localparam logic MODE_TRACE = 1'b1;

  // Number of RUN cycles for one job: trace only visits the diagonal of C.
  function automatic int iter_cycles(input int n, input int lanes, input logic mode);
    return (mode == MODE_TRACE) ? (n * n / lanes) : (n * n * n / lanes);
  endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// LANES parallel unsigned multipliers feeding an adder tree, with one output
// register stage; the sum is kept at full width so no product bits are lost.
module mac_lane_tree #(
  parameter int LANES  = 2,
  parameter int DATA_W = 8,
  parameter int SUM_W  = 2 * DATA_W + $clog2(LANES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [LANES-1:0][DATA_W-1:0] a,
  input  logic [LANES-1:0][DATA_W-1:0] b,
  output logic                         out_valid,
  output logic [SUM_W-1:0]             sum
);

  logic [SUM_W-1:0] sum_comb;

  // NOTE: blocking '=' is correct here: the loop builds one combinational
  // chain that synthesis rebalances into a tree; '<=' would break the chain.
  always_comb begin
    sum_comb = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_comb = sum_comb + SUM_W'(a[l]) * SUM_W'(b[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
    sum <= sum_comb;
  end

endmodule

// File: rtl/matmul_sum_engine.sv
// Matrix-multiply summing tile: banked A/B operand memories, a RUN/DRAIN
// controller and a LANES-wide MAC pipeline producing sum(C) or trace(C).
module matmul_sum_engine
  import matmul_pkg::*;
#(
  parameter int N      = 4,
  parameter int LANES  = 2,
  parameter int DATA_W = 8,
  parameter int RES_W  = 32,
  parameter int CNT_W  = 10
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [$clog2(N*N)-1:0] wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   start,
  input  logic                   mode,
  output logic                   busy,
  output logic [RES_W-1:0]       result,
  output logic                   overflow,
  output logic [CNT_W-1:0]       clkcount,
  output logic                   done_L
);

  localparam int LOGN  = $clog2(N);
  localparam int KB_N  = N / LANES;
  localparam int KW    = (KB_N > 1) ? $clog2(KB_N) : 1;
  localparam int DEPTH = N * N / LANES;
  localparam int IW    = $clog2(DEPTH);
  localparam int IT_W  = $clog2(N * N * N / LANES);
  localparam int SUM_W = 2 * DATA_W + $clog2(LANES);

  // Bank l holds A columns and B rows whose index is l mod LANES, so each
  // lane reads exactly one element per matrix per cycle.
  // NOTE: operand memories carry no reset; contents survive RST by design and
  // leaving them out of reset keeps them mappable to plain register files.
  logic [DATA_W-1:0] a_mem [LANES][DEPTH];
  logic [DATA_W-1:0] b_mem [LANES][DEPTH];

  state_t                      state, state_nxt;
  logic                        mode_q;
  logic [LOGN-1:0]             ci, cj;
  logic [KW-1:0]               kb;
  logic [IT_W-1:0]             iter_left;
  logic                        drain_cnt;
  logic                        accept, wr_ok, rd_valid, mac_valid;
  int                          a_wbank, b_wbank;
  logic [IW-1:0]               a_widx, b_widx, a_ridx, b_ridx;
  logic [LANES-1:0][DATA_W-1:0] a_rd, b_rd;
  logic [SUM_W-1:0]            mac_sum;
  logic [RES_W:0]              acc_nxt;

  assign accept  = start && (state == IDLE || state == DONE);
  assign wr_ok   = wr_en && !busy;
  assign acc_nxt = {1'b0, result} + (RES_W + 1)'(mac_sum);

  always_comb begin
    a_wbank = int'(wr_addr) % LANES;
    a_widx  = IW'(int'(wr_addr) / LANES);
    b_wbank = (int'(wr_addr) / N) % LANES;
    b_widx  = IW'((int'(wr_addr) / N / LANES) * N + int'(wr_addr) % N);
    a_ridx  = IW'(int'(ci) * KB_N + int'(kb));
    b_ridx  = IW'(int'(kb) * N + int'(cj));
  end

  always_ff @(posedge CLK) begin
    for (int l = 0; l < LANES; l++) begin
      if (wr_ok && !wr_sel && a_wbank == l) a_mem[l][a_widx] <= wr_data;
      if (wr_ok &&  wr_sel && b_wbank == l) b_mem[l][b_widx] <= wr_data;
      a_rd[l] <= a_mem[l][a_ridx];
      b_rd[l] <= b_mem[l][b_ridx];
    end
  end

  mac_lane_tree #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_mac (
    .clk       (CLK),
    .rst       (RST),
    .in_valid  (rd_valid),
    .a         (a_rd),
    .b         (b_rd),
    .out_valid (mac_valid),
    .sum       (mac_sum)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done_L    = 1'b1;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (iter_left == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) state_nxt = DONE;
      end
      DONE: begin
        done_L = 1'b0;
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      mode_q    <= MODE_SUM;
      ci        <= '0;
      cj        <= '0;
      kb        <= '0;
      iter_left <= '0;
      drain_cnt <= 1'b0;
      rd_valid  <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      clkcount  <= '0;
    end else begin
      state    <= state_nxt;
      rd_valid <= (state == RUN);
      if (accept) begin
        mode_q    <= mode;
        ci        <= '0;
        cj        <= '0;
        kb        <= '0;
        iter_left <= IT_W'(iter_cycles(N, LANES, mode) - 1);
        drain_cnt <= 1'b0;
        result    <= '0;
        overflow  <= 1'b0;
        clkcount  <= '0;
      end else begin
        if (state == RUN) begin
          iter_left <= iter_left - 1'b1;
          if (kb == KW'(KB_N - 1)) begin
            kb <= '0;
            // Trace walks the diagonal, so i and j advance together.
            if (mode_q == MODE_TRACE) begin
              ci <= ci + 1'b1;
              cj <= cj + 1'b1;
            end else if (cj == LOGN'(N - 1)) begin
              cj <= '0;
              ci <= ci + 1'b1;
            end else begin
              cj <= cj + 1'b1;
            end
          end else begin
            kb <= kb + 1'b1;
          end
        end
        if (state == DRAIN) drain_cnt <= 1'b1;
        if (busy && clkcount != '1) clkcount <= clkcount + 1'b1;
        if (mac_valid) begin
          result   <= acc_nxt[RES_W-1:0];
          overflow <= overflow | acc_nxt[RES_W];
        end
      end
    end
  end

endmodule
